pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised elastic pipeline-stage register, the successor to the fixed stall/flush stage registers
//   between core pipeline stages. It carries one opaque payload bus of width DW between any two stages
//   using valid/ready handshakes, with an optional 2-entry skid so that in_ready is registered (no
//   combinational ready path across stages). On reset or flush it presents a parametrised bubble value.
// PARAMETERS
//   DW        32    payload width in bits (>=1); upstream concatenates all stage fields into this bus
//   NOP_VAL   0     DW-bit bubble value driven on out_data when the stage is empty, after reset and flush
// PORTS
//   clk        in   1   rising-edge clock
//   rstn       in   1   reset, asynchronous assert, active-low
//   flush      in   1   synchronous kill of all held and incoming beats
//   in_valid   in   1   upstream beat valid
//   in_ready   out  1   stage can accept a beat; fire_in = in_valid & in_ready & ~flush
//   in_data    in   DW  upstream payload
//   out_valid  out  1   stage holds a beat; fire_out = out_valid & out_ready & ~flush
//   out_ready  in   1   downstream accepts (its inverse replaces the old stall input)
//   out_data   out  DW  head payload; NOP_VAL when out_valid=0
//   occ        out  2   entries held: 0, 1 or 2
// BEHAVIOUR
//   Reset (rstn=0, async): state=EMPTY, main=skid=NOP_VAL, out_valid=0, out_data=NOP_VAL, occ=0,
//     in_ready=1. Release takes effect at the first rising edge with rstn=1.
//   Storage: main register (head, drives out_data) and skid register (second entry).
//   States: EMPTY (occ=0), ONE (occ=1, main valid), TWO (occ=2, main+skid valid).
//     EMPTY: fire_in                -> ONE, main<=in_data.
//     ONE:   fire_in & fire_out     -> ONE, main<=in_data (1 beat/cycle throughput).
//            fire_in only           -> TWO, skid<=in_data.
//            fire_out only          -> EMPTY, main<=NOP_VAL.
//     TWO:   fire_out               -> ONE, main<=skid, skid<=NOP_VAL. No input is accepted in TWO.
//   in_ready = (state!=TWO), registered. out_valid = (state!=EMPTY), registered.
//   Latency: a beat accepted at edge N is visible on out_data after edge N (one cycle, in-to-out).
//   Order is strict FIFO. No beat is duplicated or dropped except by flush.
//   Flush (sync, highest priority): at the next edge state->EMPTY, main=skid=NOP_VAL. The beat offered
//     in the flush cycle is discarded, and so is the beat held on out_data (fire_out is masked).
//     flush together with reset: reset wins.
//   Payload is never modified; it is width-exact and has no arithmetic.
//   out_data on a held beat is stable while out_valid=1 and out_ready=0 (AXI-style hold rule).
// CONFIGURATION
//   PIPE_SKID_EN defined: 2-entry skid as above; in_ready has no combinational dependence on out_ready.
//   PIPE_SKID_EN undefined: skid register and TWO state are removed. in_ready = ~out_valid | out_ready
//     (combinational) and occ never exceeds 1. Per-edge behaviour, reset and flush are otherwise identical.
// STRUCTURE
//   Defines.v: PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2 state encodings; PIPE_SKID_EN default setting
//     in Config.v.
//   Single flat module; no sub-module (only two storage registers plus a 2-bit FSM).
// TESTING
//   1. Hold rstn=0 with in_valid=1 -> out_valid=0, out_data=NOP_VAL, occ=0, in_ready=1; still 0 one edge
//      after release with in_valid=0.
//   2. Stream 0x11,0x22,0x33 with out_ready=1 -> out_data shows 0x11,0x22,0x33 on consecutive cycles,
//      occ=1 throughout.
//   3. SKID_EN: out_ready=0, send 0xA,0xB,0xC -> 0xA,0xB accepted, occ=2, in_ready=0, 0xC held upstream;
//      raise out_ready -> output order 0xA,0xB,0xC with no loss.
//   4. occ=2 (0xA,0xB) and flush=1 with in_valid=1 (0xD) -> next cycle occ=0, out_valid=0,
//      out_data=NOP_VAL, 0xD never appears.
//   5. !SKID_EN: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1
//      -> replace in one edge, occ stays 1.
//   6. Assert rstn=0 mid-stream at occ=2, asynchronously between edges -> outputs return to reset values
//      before the next edge.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_pkg
//   Shared definitions for the elastic pipeline-stage register.
//   - ps_state_e : occupancy state of the stage (EMPTY / ONE / TWO)
//   - ps_occ()   : maps a state to its entry count for the occ port
// -----------------------------------------------------------------------------
package pipe_stage_elastic_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_e;

    function automatic logic [1:0] ps_occ(input ps_state_e s);
        unique case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic valid/ready pipeline-stage register carrying an opaque DW-bit
//   payload. An empty stage presents NOP_VAL on out_data.
//
//   Build option:
//     PIPE_SKID_EN defined   : 2-entry skid, in_ready registered (no
//                              combinational path from out_ready).
//     PIPE_SKID_EN undefined : single entry, in_ready = ~out_valid | out_ready.
//
//   Ports:
//     clk        rising-edge clock
//     rstn       asynchronous active-low reset
//     flush      synchronous kill of held and incoming beats (beats reset)
//     in_valid   upstream beat valid
//     in_ready   stage can accept a beat
//     in_data    upstream payload (DW bits)
//     out_valid  stage holds a beat
//     out_ready  downstream accepts
//     out_data   head payload, NOP_VAL when out_valid=0
//     occ        entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int unsigned     DW      = 32,
    parameter logic [DW-1:0]   NOP_VAL = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    ps_state_e     state;
    logic [DW-1:0] main_q;
    logic          out_valid_q;
    logic          fire_in;
    logic          fire_out;

    assign fire_in   = in_valid & in_ready & ~flush;
    assign fire_out  = out_valid_q & out_ready & ~flush;

    // main_q is reloaded with NOP_VAL whenever the stage empties, so it can
    // drive out_data directly without a mux on out_valid.
    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign occ       = ps_occ(state);

`ifdef PIPE_SKID_EN

    logic [DW-1:0] skid_q;
    logic          in_ready_q;

    assign in_ready = in_ready_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= PS_EMPTY;
            main_q      <= NOP_VAL;
            skid_q      <= NOP_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= PS_EMPTY;
            main_q      <= NOP_VAL;
            skid_q      <= NOP_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (fire_in) begin
                        state       <= PS_ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                PS_ONE: begin
                    if (fire_in && fire_out) begin
                        main_q <= in_data;
                    end else if (fire_in) begin
                        state      <= PS_TWO;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (fire_out) begin
                        state       <= PS_EMPTY;
                        main_q      <= NOP_VAL;
                        out_valid_q <= 1'b0;
                    end
                end
                PS_TWO: begin
                    if (fire_out) begin
                        state      <= PS_ONE;
                        main_q     <= skid_q;
                        skid_q     <= NOP_VAL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= PS_EMPTY;
                    main_q      <= NOP_VAL;
                    skid_q      <= NOP_VAL;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`else

    // Without the skid entry the stage can only take a beat when it is empty
    // or its head is leaving in the same cycle.
    assign in_ready = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= PS_EMPTY;
            main_q      <= NOP_VAL;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= PS_EMPTY;
            main_q      <= NOP_VAL;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (fire_in) begin
                        state       <= PS_ONE;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                PS_ONE: begin
                    // in_ready forces fire_in to imply fire_out here
                    if (fire_in) begin
                        main_q <= in_data;
                    end else if (fire_out) begin
                        state       <= PS_EMPTY;
                        main_q      <= NOP_VAL;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= PS_EMPTY;
                    main_q      <= NOP_VAL;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//   Self-checking bench for pipe_stage_elastic. A queue-based model of the
//   stage (capacity 2 with PIPE_SKID_EN, else 1) predicts every output each
//   cycle; directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int unsigned   DW  = 8;
    localparam logic [DW-1:0] NOP = 8'hA5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DW      (DW),
        .NOP_VAL (NOP)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ordered list of beats currently held by the stage.
    logic [DW-1:0] mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic exp_in_ready();
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        logic [DW-1:0] head;
        head = (mq.size() != 0) ? mq[0] : NOP;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, ".out_data"},  32'(out_data),  32'(head));
        check({tag, ".occ"},       32'(occ),       32'(mq.size()));
        check({tag, ".in_ready"},  32'(in_ready),  32'(exp_in_ready()));
    endtask

    // Drive one cycle of inputs (called #1 after a rising edge), check the
    // outputs against the model, advance the model across the edge.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic f);
        logic acc;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        check_outputs(tag);
        acc = v && exp_in_ready() && !f;
        if (f) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && r) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  32'(out_data),  32'(NOP));
        check({tag, ".occ"},       32'(occ),       32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    endtask

    logic [DW-1:0] stream [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        // Reset held with a valid beat offered
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rstn = 1'b1;
        cycle("rel", 1'b0, 8'h00, 1'b1, 1'b0);
        check_reset_vals("rel_after");

        // Streaming at full throughput
        for (int i = 0; i < 3; i++) begin
            cycle("stream", 1'b1, stream[i], 1'b1, 1'b0);
            check("stream.data", 32'(out_data), 32'(stream[i]));
            check("stream.occ",  32'(occ), 32'd1);
        end
        cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: fill, hold, then release with no loss
        cycle("bp", 1'b1, 8'h0A, 1'b0, 1'b0);
        cycle("bp", 1'b1, 8'h0B, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
        check("bp.occ2", 32'(occ), 32'd2);
        check("bp.in_ready0", 32'(in_ready), 32'd0);
`endif
        cycle("bp", 1'b1, 8'h0C, 1'b0, 1'b0);
        cycle("bp", 1'b1, 8'h0C, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("bp_rel", 1'b1, 8'h0C, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while full with a beat offered
        cycle("fl", 1'b1, 8'h0A, 1'b0, 1'b0);
        cycle("fl", 1'b1, 8'h0B, 1'b0, 1'b0);
        cycle("fl", 1'b1, 8'h0D, 1'b1, 1'b1);
        check_reset_vals("fl_after");
        cycle("fl_post", 1'b0, 8'h00, 1'b1, 1'b0);

        // Same-cycle ready dependence and replace-in-one-edge
        cycle("rep", 1'b1, 8'h44, 1'b0, 1'b0);
        cycle("rep", 1'b1, 8'h55, 1'b0, 1'b0);
        cycle("rep", 1'b1, 8'h66, 1'b1, 1'b0);
        cycle("rep", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, between edges
        cycle("ar", 1'b1, 8'h01, 1'b0, 1'b0);
        cycle("ar", 1'b1, 8'h02, 1'b0, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        mq.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle("ar_post", 1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd",
                  1'($urandom_range(0, 3) != 0),
                  DW'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
